// File: rtl/ladder_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ladder_seq_ctrl
//
// Sequencing controller for the fault-tolerant scalar key scanner of the ECC
// point-multiplication core. It loads and judges the scalar, then locates the
// leading one. It walks the remaining key bits one Montgomery-ladder step at a
// time and hands each bit to the ladder datapath over a req/done handshake.
// When the fault-retry build is enabled, it also checkpoints the scanner after
// every good step and rewinds it to retry a faulted bit.
//
// Build option:
//   LADDER_FAULT_RETRY_EN  defined   -> snapshot/commit/restore and retry
//                                       counting are present.
//                          undefined -> FIND_W and good steps go straight to
//                                       TEST. step_fault_i is ignored, and
//                                       err_o and kscan_op_o are tied low.
//
// Parameters:
//   N          scalar width (must match the scanner, N <= 255)
//   MAX_RETRY  consecutive restores allowed for one bit before error
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   start_i                   begin a multiplication (sampled in IDLE only)
//   kscan_ki_i                scanned key bit from the scanner
//   kscan_first_found_i       leading one located (sticky until reload)
//   kscan_cnt_i[7:0]          scanner shift count
//   kscan_state_i[1:0]        judge result: 00 normal, 01 key==0, 11 key==1
//   kscan_load_o/check_o/find_en_o/scan_en_o   one-cycle scanner commands
//   kscan_op_o[1:0]           backup op: 01 snapshot, 10 commit, 11 restore
//   step_req_o, step_bit_o    ladder step request and its key bit
//   step_done_i, step_fault_i step completion and fault flag
//   busy_o, done_o, err_o     status; err_o is sticky until the next start
//   result_special_o[1:0]     latched judge result, valid with done_o
// ---------------------------------------------------------------------------
module ladder_seq_ctrl #(
  parameter int N         = 233,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       kscan_ki_i,
  input  logic       kscan_first_found_i,
  input  logic [7:0] kscan_cnt_i,
  input  logic [1:0] kscan_state_i,
  output logic       kscan_load_o,
  output logic       kscan_check_o,
  output logic       kscan_find_en_o,
  output logic       kscan_scan_en_o,
  output logic [1:0] kscan_op_o,
  output logic       step_req_o,
  output logic       step_bit_o,
  input  logic       step_done_i,
  input  logic       step_fault_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [1:0] result_special_o
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_LOAD, ST_CHECK, ST_JUDGE_W, ST_FIND, ST_FIND_W, ST_SNAP,
    ST_COMMIT, ST_TEST, ST_SCAN, ST_SCAN_W, ST_STEP, ST_RESTORE, ST_DONE,
    ST_ERROR
  } state_e;

  // Unsigned 8-bit end-of-key compare against the scanner count.
  localparam logic [7:0] CNT_END = 8'(N);

  state_e     state_q, state_d;
  logic       wait_q, wait_d;          // second cycle of a 2-cycle wait state
  logic       step_bit_q, step_bit_d;
  logic [1:0] special_q, special_d;

`ifdef LADDER_FAULT_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_q, retry_d;
  logic          err_q, err_d;
`else
  localparam int unused_max_retry = MAX_RETRY;
  logic unused_step_fault;
  assign unused_step_fault = step_fault_i;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wait_q     <= 1'b0;
      step_bit_q <= 1'b0;
      special_q  <= 2'b00;
`ifdef LADDER_FAULT_RETRY_EN
      retry_q    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      step_bit_q <= step_bit_d;
      special_q  <= special_d;
`ifdef LADDER_FAULT_RETRY_EN
      retry_q    <= retry_d;
      err_q      <= err_d;
`endif
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_d     = 1'b0;
    step_bit_d = step_bit_q;
    special_d  = special_q;
`ifdef LADDER_FAULT_RETRY_EN
    retry_d    = retry_q;
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LOAD;
`ifdef LADDER_FAULT_RETRY_EN
          retry_d = '0;
          err_d   = 1'b0;
`endif
        end
      end
      ST_LOAD:  state_d = ST_CHECK;
      ST_CHECK: state_d = ST_JUDGE_W;
      ST_JUDGE_W: begin
        if (!wait_q) begin
          wait_d = 1'b1;
        end else begin
          special_d = kscan_state_i;
          // A special key (0 or 1) needs no ladder steps at all.
          state_d   = (kscan_state_i != 2'b00) ? ST_DONE : ST_FIND;
        end
      end
      ST_FIND: state_d = ST_FIND_W;
      ST_FIND_W: begin
        // The leading one itself is consumed without a ladder step.
        if (kscan_first_found_i) begin
`ifdef LADDER_FAULT_RETRY_EN
          state_d = ST_SNAP;
`else
          state_d = ST_TEST;
`endif
        end
      end
`ifdef LADDER_FAULT_RETRY_EN
      ST_SNAP:    state_d = ST_COMMIT;
      ST_COMMIT:  state_d = ST_TEST;
      ST_RESTORE: state_d = ST_SCAN;  // rewound scanner rescans the same bit
`endif
      ST_TEST: state_d = (kscan_cnt_i == CNT_END) ? ST_DONE : ST_SCAN;
      ST_SCAN: state_d = ST_SCAN_W;
      ST_SCAN_W: begin
        if (!wait_q) begin
          wait_d = 1'b1;
        end else begin
          step_bit_d = kscan_ki_i;
          state_d    = ST_STEP;
        end
      end
      ST_STEP: begin
        if (step_done_i) begin
`ifdef LADDER_FAULT_RETRY_EN
          if (!step_fault_i) begin
            retry_d = '0;
            state_d = ST_SNAP;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_RESTORE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end
`else
          state_d = ST_TEST;
`endif
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Scanner commands are decoded from the state alone, so at most one of them
  // is active in any cycle.
  always_comb begin
    kscan_load_o    = 1'b0;
    kscan_check_o   = 1'b0;
    kscan_find_en_o = 1'b0;
    kscan_scan_en_o = 1'b0;
    kscan_op_o      = 2'b00;
    case (state_q)
      ST_LOAD:    kscan_load_o    = 1'b1;
      ST_CHECK:   kscan_check_o   = 1'b1;
      ST_FIND:    kscan_find_en_o = 1'b1;
      ST_SCAN:    kscan_scan_en_o = 1'b1;
`ifdef LADDER_FAULT_RETRY_EN
      ST_SNAP:    kscan_op_o      = 2'b01;
      ST_COMMIT:  kscan_op_o      = 2'b10;
      ST_RESTORE: kscan_op_o      = 2'b11;
`endif
      default: ;
    endcase
  end

  assign step_req_o       = (state_q == ST_STEP);
  assign step_bit_o       = step_bit_q;
  assign busy_o           = (state_q != ST_IDLE);
  assign done_o           = (state_q == ST_DONE);
  assign result_special_o = special_q;
`ifdef LADDER_FAULT_RETRY_EN
  assign err_o            = err_q;
`else
  assign err_o            = 1'b0;
`endif

endmodule

// File: tb/tb_ladder_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ladder_seq_ctrl
//
// Self-checking bench for ladder_seq_ctrl with N=8, MAX_RETRY=3. A behavioural
// key scanner and a ladder datapath with random latency surround the DUT.
// For each multiplication, a reference model derives the expected stream of
// step bits, the final done/error event and the restore count directly from
// the key value and the planned per-bit fault counts. A monitor pops and
// compares that stream as the DUT presents step requests and completions.
// ---------------------------------------------------------------------------
module tb_ladder_seq_ctrl;
  localparam int N         = 8;
  localparam int MAX_RETRY = 3;
`ifdef LADDER_FAULT_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start;
  logic       kscan_ki, kscan_first_found;
  logic [7:0] kscan_cnt;
  logic [1:0] kscan_state;
  logic       kscan_load, kscan_check, kscan_find_en, kscan_scan_en;
  logic [1:0] kscan_op;
  logic       step_req, step_bit, step_done, step_fault;
  logic       busy, done, err;
  logic [1:0] result_special;

  always #5 clk = ~clk;

  ladder_seq_ctrl #(.N(N), .MAX_RETRY(MAX_RETRY)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .start_i            (start),
    .kscan_ki_i         (kscan_ki),
    .kscan_first_found_i(kscan_first_found),
    .kscan_cnt_i        (kscan_cnt),
    .kscan_state_i      (kscan_state),
    .kscan_load_o       (kscan_load),
    .kscan_check_o      (kscan_check),
    .kscan_find_en_o    (kscan_find_en),
    .kscan_scan_en_o    (kscan_scan_en),
    .kscan_op_o         (kscan_op),
    .step_req_o         (step_req),
    .step_bit_o         (step_bit),
    .step_done_i        (step_done),
    .step_fault_i       (step_fault),
    .busy_o             (busy),
    .done_o             (done),
    .err_o              (err),
    .result_special_o   (result_special)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef enum int {EV_STEP, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [1:0] val;
  } ev_t;

  ev_t exp_q[$];
  bit  fault_plan[$];      // step_fault value for each successive handshake
  int  fault_cnt[N];       // planned faults for each key bit position
  int  exp_restores;
  bit  exp_err;

  function automatic void push_ev(input ev_kind_e k, input logic [1:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  // Reference model: bits below the leading one are stepped MSB first. A bit
  // with f faults is stepped f+1 times. If f exceeds MAX_RETRY, the bit is
  // stepped MAX_RETRY+1 times and the run ends in error.
  task automatic build_model(input logic [N-1:0] key);
    int p;
    int f;
    exp_q.delete();
    fault_plan.delete();
    exp_restores = 0;
    exp_err      = 1'b0;
    if (key == 0) begin
      push_ev(EV_DONE, 2'b01);
    end else if (key == 1) begin
      push_ev(EV_DONE, 2'b11);
    end else begin
      p = N - 1;
      while (!key[p]) p--;
      for (int j = p - 1; j >= 0; j--) begin
        f = RETRY_EN ? fault_cnt[j] : 0;
        if (!RETRY_EN) fault_plan.push_back(fault_cnt[j] != 0);
        if (f > MAX_RETRY) begin
          repeat (MAX_RETRY + 1) begin
            push_ev(EV_STEP, {1'b0, key[j]});
            fault_plan.push_back(1'b1);
          end
          exp_restores += MAX_RETRY;
          exp_err = 1'b1;
          push_ev(EV_ERR, 2'b00);
          return;
        end
        repeat (f) begin
          push_ev(EV_STEP, {1'b0, key[j]});
          fault_plan.push_back(1'b1);
        end
        push_ev(EV_STEP, {1'b0, key[j]});
        if (RETRY_EN) fault_plan.push_back(1'b0);
        exp_restores += f;
      end
      push_ev(EV_DONE, 2'b00);
    end
  endtask

  // ---------------- behavioural key scanner ----------------
  logic [N-1:0] scan_key;   // key the scanner loads on kscan_load
  logic [N-1:0] sc_key;
  int sc_cnt, sc_tmp, sc_commit, find_wait;
  bit finding;

  function automatic int lead_shift(input logic [N-1:0] k);
    for (int i = N - 1; i >= 0; i--)
      if (k[i]) return N - i;
    return N;
  endfunction

  initial begin
    kscan_ki = 1'b0; kscan_first_found = 1'b0; kscan_cnt = '0; kscan_state = 2'b00;
    sc_key = '0; sc_cnt = 0; sc_tmp = 0; sc_commit = 0; find_wait = 0; finding = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sc_cnt = 0; sc_tmp = 0; sc_commit = 0; finding = 1'b0;
        kscan_ki = 1'b0; kscan_first_found = 1'b0; kscan_state = 2'b00;
      end else begin
        if (finding) begin
          if (find_wait == 0) begin
            finding = 1'b0;
            sc_cnt = lead_shift(sc_key);
            kscan_first_found = 1'b1;
          end else begin
            find_wait--;
          end
        end
        if (kscan_load) begin
          sc_key = scan_key; sc_cnt = 0; finding = 1'b0;
          kscan_first_found = 1'b0; kscan_state = 2'b00;
        end
        if (kscan_check)
          kscan_state = (sc_key == 0) ? 2'b01 : ((sc_key == 1) ? 2'b11 : 2'b00);
        if (kscan_find_en) begin
          finding = 1'b1;
          find_wait = $urandom_range(0, 2);
        end
        if (kscan_scan_en && sc_cnt < N) begin
          sc_cnt++;
          kscan_ki = sc_key[N - sc_cnt];
        end
        case (kscan_op)
          2'b01: sc_tmp = sc_cnt;
          2'b10: sc_commit = sc_tmp;
          2'b11: sc_cnt = sc_commit;
          default: ;
        endcase
      end
      kscan_cnt = 8'(sc_cnt);
    end
  end

  // ---------------- ladder datapath ----------------
  bit dp_active;
  int dp_wait;

  initial begin
    step_done = 1'b0; step_fault = 1'b0; dp_active = 1'b0; dp_wait = 0;
    forever begin
      @(negedge clk);
      step_done = 1'b0;
      step_fault = 1'b0;
      if (rst) begin
        dp_active = 1'b0;
      end else if (!step_req) begin
        dp_active = 1'b0;
        // Stray completions outside a step must be ignored by the DUT.
        if ($urandom_range(0, 7) == 0) begin
          step_done = 1'b1;
          step_fault = 1'($urandom_range(0, 1));
        end
      end else begin
        if (!dp_active) begin
          dp_active = 1'b1;
          dp_wait = $urandom_range(0, 3);
        end
        if (dp_wait == 0) begin
          step_done = 1'b1;
          if (fault_plan.size() > 0) step_fault = fault_plan.pop_front();
        end else begin
          dp_wait--;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int   restore_cnt = 0;
  int   viol_cnt = 0;
  logic prev_req = 1'b0, prev_err = 1'b0, prev_bit = 1'b0;

  initial begin
    int  ncmd;
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ncmd = int'(kscan_load) + int'(kscan_check) + int'(kscan_find_en) +
               int'(kscan_scan_en) + int'(kscan_op != 2'b00);
        if (ncmd > 1) viol_cnt++;
        if (!RETRY_EN && kscan_op != 2'b00) viol_cnt++;
        if (kscan_op == 2'b11) restore_cnt++;
        if (step_req && prev_req && step_bit != prev_bit) viol_cnt++;
        if (step_req && !prev_req) begin
          check("event pending at step_req", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("event kind at step_req", 32'(e.kind), 32'(EV_STEP));
            check("step_bit", 32'(step_bit), 32'(e.val));
          end
        end
        if (done) begin
          check("event pending at done", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("event kind at done", 32'(e.kind), 32'(EV_DONE));
            check("result_special", 32'(result_special), 32'(e.val));
            check("err low at done", 32'(err), 0);
          end
        end
        if (err && !prev_err) begin
          check("event pending at err", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("event kind at err", 32'(e.kind), 32'(EV_ERR));
          end
        end
      end
      prev_req = step_req;
      prev_err = err;
      prev_bit = step_bit;
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, " commands"}, 32'({kscan_load, kscan_check, kscan_find_en, kscan_scan_en}), 0);
    check({tag, " kscan_op"}, 32'(kscan_op), 0);
    check({tag, " step_req"}, 32'(step_req), 0);
    check({tag, " step_bit"}, 32'(step_bit), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " err"}, 32'(err), 0);
    check({tag, " result_special"}, 32'(result_special), 0);
  endtask

  task automatic clear_faults();
    for (int j = 0; j < N; j++) fault_cnt[j] = 0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic run_mult(input logic [N-1:0] key, input bit poke_start);
    int cyc;
    bit fin;
    build_model(key);
    scan_key = key;
    restore_cnt = 0;
    viol_cnt = 0;
    start = 1'b1;
    cyc = 1;
    @(negedge clk);
    start = 1'b0;
    cyc = 2;
    check("busy after start accept", 32'(busy), 1);
    check("err cleared by start", 32'(err), 0);
    fin = 1'b0;
    while (!fin && cyc < 3000) begin
      if (done || err) begin
        fin = 1'b1;
      end else begin
        start = (poke_start && cyc == 3);
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check("run finished within budget", 32'(fin), 1);
    if (key == 0 || key == 1) check("special start-to-done cycles", cyc, 6);
    @(negedge clk);
    check("busy low after exit", 32'(busy), 0);
    check("expected events consumed", exp_q.size(), 0);
    check("restore count", restore_cnt, exp_restores);
    check("protocol violations", viol_cnt, 0);
    check("err after exit", 32'(err), 32'(exp_err));
    if (!fin) begin
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  initial begin
    logic [N-1:0] rk;
    int n;
    rst = 1'b1;
    start = 1'b0;
    scan_key = '0;
    clear_faults();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_mult(8'b0010_1101, 1'b0);
    run_mult(8'h00, 1'b1);
    run_mult(8'h01, 1'b0);
    fault_cnt[3] = 1;                 // second step faults once
    run_mult(8'b0010_1101, 1'b0);
    fault_cnt[3] = 4;                 // exceeds the retry budget
    run_mult(8'b0010_1101, 1'b0);
    clear_faults();
    run_mult(8'b0010_1101, 1'b1);     // err clears on the next start
    run_mult(8'h80, 1'b0);
    run_mult(8'hFF, 1'b0);
    run_mult(8'h02, 1'b0);

    // Reset in the middle of a step.
    build_model(8'b0010_1101);
    scan_key = 8'b0010_1101;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!step_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached STEP before reset", 32'(step_req), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid-step reset");
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    fault_plan.delete();
    run_mult(8'b0010_1101, 1'b0);

    // Randomized keys and fault patterns.
    for (int it = 0; it < 40; it++) begin
      rk = N'($urandom());
      if (it % 13 == 0) rk = '0;
      if (it % 13 == 7) rk = 1;
      for (int j = 0; j < N; j++) begin
        n = $urandom_range(0, 15);
        fault_cnt[j] = (n < 12) ? 0 : (n < 14) ? 1 : (n == 14) ? 2 : 4;
      end
      run_mult(rk, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
